// File: rtl/conv_pkg.sv
// Shared types and widths for the 3x3-kernel / 4x4-window convolution front end.
// A window column is four stacked pixels, with the oldest row in the low byte.
package conv_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_DIM = 4;
  localparam int WIN_PIX = WIN_DIM * WIN_DIM;
  localparam int WIN_W   = PIX_W * WIN_PIX;
  localparam int WGT_W   = 72;
  localparam int COL_W   = WIN_DIM * PIX_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Four columns (c0 = leftmost) -> row-major window, byte 4*i+j = row i, column j.
  function automatic logic [WIN_W-1:0] pack_window(
    input logic [COL_W-1:0] c0,
    input logic [COL_W-1:0] c1,
    input logic [COL_W-1:0] c2,
    input logic [COL_W-1:0] c3
  );
    logic [WIN_DIM-1:0][COL_W-1:0] cols;
    logic [WIN_W-1:0]              w;
    cols = {c3, c2, c1, c0};
    w    = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      for (int j = 0; j < WIN_DIM; j++) begin
        w[PIX_W*(WIN_DIM*i+j) +: PIX_W] = cols[j][PIX_W*i +: PIX_W];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream, weight load and window output bundle of conv_window_gen.
// Handshake: a pixel moves on a rising edge where pix_vld && pix_rdy; win_vld is a one-cycle pulse with no backpressure.
interface conv_window_gen_if #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
);
  import conv_pkg::*;

  logic                     start;
  logic                     pix_vld;
  logic [PIX_W-1:0]         pix_data;
  logic                     pix_rdy;
  logic                     wgt_ld;
  logic [WGT_W-1:0]         wgt_i;
  logic [WGT_W-1:0]         wgt_o;
  logic                     win_vld;
  logic [WIN_W-1:0]         win_data;
  logic [$clog2(IMG_H)-1:0] win_row;
  logic [$clog2(IMG_W)-1:0] win_col;
  logic                     frame_done;

  modport slave (
    input  start, pix_vld, pix_data, wgt_ld, wgt_i,
    output pix_rdy, wgt_o, win_vld, win_data, win_row, win_col, frame_done
  );

  modport master (
    output start, pix_vld, pix_data, wgt_ld, wgt_i,
    input  pix_rdy, wgt_o, win_vld, win_data, win_row, win_col, frame_done
  );

endinterface

// File: rtl/conv_line_buf.sv
// One image row of byte storage. The read is combinational, so a same-cycle write at
// the same column lands after the old value has been read out.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [PIX_W-1:0]         wdata_i,
  output logic [PIX_W-1:0]         rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream -> stride-2 4x4 windows for a 2x2 output tile of a 3x3 convolution.
// Three line buffers supply rows r-3..r-1 above the incoming pixel.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  conv_window_gen_if.slave        bus,
  output state_t                  state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t                    state_q;
  logic [CW-1:0]             col_q;
  logic [RW-1:0]             row_q;
  logic [WGT_W-1:0]          wgt_q;
  logic                      win_vld_q;
  logic                      frame_done_q;
  logic [WIN_W-1:0]          win_data_q;
  logic [RW-1:0]             win_row_q;
  logic [CW-1:0]             win_col_q;
  logic [2:0][COL_W-1:0]     colhist_q;

  logic                      accept;
  logic                      last_pix;
  logic                      emit;
  logic [PIX_W-1:0]          lb0_rd, lb1_rd, lb2_rd;
  logic [COL_W-1:0]          new_col;
  logic [WIN_W-1:0]          win_data_d;
  logic [RW-1:0]             win_row_d;
  logic [CW-1:0]             win_col_d;

  assign accept   = (state_q == ST_RUN) && bus.pix_vld;
  assign last_pix = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  // Stride-2 origins: the window's bottom-right pixel sits on an odd row and odd column >= 3.
  assign emit     = (row_q >= RW'(3)) && row_q[0] && (col_q >= CW'(3)) && col_q[0];

  conv_line_buf #(.DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .we_i(accept), .addr_i(col_q), .wdata_i(lb1_rd), .rdata_o(lb0_rd)
  );
  conv_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .we_i(accept), .addr_i(col_q), .wdata_i(lb2_rd), .rdata_o(lb1_rd)
  );
  conv_line_buf #(.DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .we_i(accept), .addr_i(col_q), .wdata_i(bus.pix_data), .rdata_o(lb2_rd)
  );

  // The fourth window column is the one arriving now, so only three are kept in flops.
  assign new_col    = {bus.pix_data, lb2_rd, lb1_rd, lb0_rd};
  assign win_data_d = pack_window(colhist_q[0], colhist_q[1], colhist_q[2], new_col);
  assign win_row_d  = (row_q >> 1) - RW'(1);
  assign win_col_d  = (col_q >> 1) - CW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      wgt_q        <= '0;
      win_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      colhist_q    <= '0;
    end else begin
      win_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (bus.wgt_ld) begin
          wgt_q <= bus.wgt_i;
        end
        if (bus.start) begin
          state_q <= ST_RUN;
          col_q   <= '0;
          row_q   <= '0;
        end
      end else if (bus.pix_vld) begin
        colhist_q <= {new_col, colhist_q[2], colhist_q[1]};
        if (col_q == CW'(IMG_W-1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (emit) begin
          win_vld_q  <= 1'b1;
          win_data_q <= win_data_d;
          win_row_q  <= win_row_d;
          win_col_q  <= win_col_d;
        end
        if (last_pix) begin
          frame_done_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
      end
    end
  end

  assign bus.pix_rdy    = (state_q == ST_RUN);
  assign bus.wgt_o      = wgt_q;
  assign bus.win_vld    = win_vld_q;
  assign bus.win_data   = win_data_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 2-D image model predicts every window, checked each cycle,
// plus literal pins on the ramp-frame windows, weight register and abort behaviour.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int W = 16;
  localparam int H = 16;
  localparam logic [WGT_W-1:0] WGT_A = 72'h010203040506070809;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  state_t state;

  always #5 clk = ~clk;

  conv_window_gen_if #(.IMG_W(W), .IMG_H(H)) bus ();

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .state_o(state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {row[3:0], col[3:0], data[127:0]}.
  logic [135:0] exp_q[$];
  logic [135:0] obs_q[$];
  int           done_at;

  bit               m_run;
  logic [WGT_W-1:0] m_wgt;
  logic [135:0]     m_hold;
  int               mr, mc;
  logic [7:0]       img [H][W];
  bit               p_acc, p_emit, p_last, p_start, p_wgt;
  logic [WGT_W-1:0] p_wgt_val;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [135:0] model_window(input int r, input int c);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        d[8*(4*i+j) +: 8] = img[r-3+i][c-3+j];
    return {4'((r-3)/2), 4'((c-3)/2), d};
  endfunction

  // Compare process: outputs seen at a falling edge reflect inputs captured one falling edge earlier.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_win_vld", bus.win_vld, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_pix_rdy", bus.pix_rdy, 0);
      chk("rst_wgt_o", bus.wgt_o, 0);
      chk("rst_win_out", {bus.win_row, bus.win_col, bus.win_data}, 0);
      chk("rst_state", state, ST_IDLE);
      m_run = 0; m_wgt = '0; m_hold = '0;
      p_acc = 0; p_emit = 0; p_last = 0; p_start = 0; p_wgt = 0;
      exp_q.delete();
    end else begin
      if (p_wgt) m_wgt = p_wgt_val;
      if (p_start) m_run = 1;
      if (p_acc && p_last) m_run = 0;
      chk("win_vld", bus.win_vld, p_emit);
      chk("frame_done", bus.frame_done, p_acc && p_last);
      chk("wgt_o", bus.wgt_o, m_wgt);
      chk("pix_rdy", bus.pix_rdy, m_run);
      chk("state", state == ST_RUN, m_run);
      if (bus.win_vld) obs_q.push_back({bus.win_row, bus.win_col, bus.win_data});
      if (bus.frame_done) done_at = obs_q.size();
      if (p_emit) m_hold = exp_q.pop_front();
      chk("win_out", {bus.win_row, bus.win_col, bus.win_data}, m_hold);
      p_acc  = bus.pix_vld && m_run;
      p_emit = 0;
      p_last = 0;
      if (p_acc) begin
        img[mr][mc] = bus.pix_data;
        p_last = (mr == H-1) && (mc == W-1);
        if (mr >= 3 && mr % 2 == 1 && mc >= 3 && mc % 2 == 1) begin
          p_emit = 1;
          exp_q.push_back(model_window(mr, mc));
        end
        if (mc == W-1) begin mc = 0; mr++; end else mc++;
      end
      p_start = bus.start && !m_run;
      if (p_start) begin mr = 0; mc = 0; end
      p_wgt     = bus.wgt_ld && !m_run;
      p_wgt_val = bus.wgt_i;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit gaps, input bit rnd, input bit poke);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 4*n + 50) begin
      @(posedge clk); #1;
      bus.start  = poke && (cyc == 20);
      bus.wgt_ld = poke && (cyc == 20);
      bus.wgt_i  = (poke && cyc == 20) ? {9{8'hFF}} : '0;
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.pix_vld = 1'b0;
      end else begin
        bus.pix_vld  = 1'b1;
        bus.pix_data = rnd ? 8'($urandom_range(0, 255)) : 8'(idx);
      end
      @(negedge clk);
      if (bus.pix_vld && bus.pix_rdy) idx++;
      cyc++;
    end
    chk("frame_pixels", idx, n);
    @(posedge clk); #1;
    bus.pix_vld = 1'b0;
    bus.start   = 1'b0;
    bus.wgt_ld  = 1'b0;
  endtask

  task automatic check_ramp_log(input string tag);
    logic [135:0] o;
    chk({tag, "_count"}, obs_q.size(), 49);
    chk({tag, "_done_at"}, done_at, 49);
    if (obs_q.size() == 49) begin
      o = obs_q[0];
      chk({tag, "_w0_b0"}, o[7:0], 8'h00);
      chk({tag, "_w0_b3"}, o[31:24], 8'h03);
      chk({tag, "_w0_b4"}, o[39:32], 8'h10);
      chk({tag, "_w0_b15"}, o[127:120], 8'h33);
      chk({tag, "_w0_pos"}, o[135:128], 8'h00);
      o = obs_q[1];
      chk({tag, "_w1_b0"}, o[7:0], 8'h02);
      chk({tag, "_w1_pos"}, o[135:128], 8'h01);
      o = obs_q[48];
      chk({tag, "_w48_b15"}, o[127:120], 8'hFF);
      chk({tag, "_w48_pos"}, o[135:128], 8'h66);
    end
  endtask

  initial begin
    bus.start = 0; bus.pix_vld = 0; bus.pix_data = 0; bus.wgt_ld = 0; bus.wgt_i = '0;
    done_at = -1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Weight load and pixel offer while idle.
    @(posedge clk); #1;
    bus.pix_vld = 1'b1; bus.pix_data = 8'hAA; bus.wgt_ld = 1'b1; bus.wgt_i = WGT_A;
    @(posedge clk); #1;
    bus.wgt_ld = 1'b0; bus.wgt_i = '0;
    @(negedge clk);
    chk("wgt_idle_load", bus.wgt_o, WGT_A);
    chk("idle_pix_rdy", bus.pix_rdy, 0);
    repeat (3) @(posedge clk);
    #1 bus.pix_vld = 1'b0;

    // Continuous ramp frame with start and wgt_ld poked mid-run.
    obs_q.delete(); done_at = -1;
    pulse_start();
    drive_pixels(W*H, 0, 0, 1);
    repeat (4) @(negedge clk);
    check_ramp_log("ramp");
    chk("wgt_kept_in_run", bus.wgt_o, WGT_A);

    // Same ramp with random stalls.
    obs_q.delete(); done_at = -1;
    pulse_start();
    drive_pixels(W*H, 1, 0, 0);
    repeat (4) @(negedge clk);
    check_ramp_log("gaps");

    // Abort after 100 pixels.
    obs_q.delete(); done_at = -1;
    pulse_start();
    drive_pixels(100, 0, 0, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_state", state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_windows", obs_q.size(), 14);
    chk("abort_no_done", done_at, -1);

    // Full ramp after the abort.
    obs_q.delete(); done_at = -1;
    pulse_start();
    drive_pixels(W*H, 0, 0, 0);
    repeat (4) @(negedge clk);
    check_ramp_log("after_rst");

    // Random pixel content with stalls; content is checked by the model.
    obs_q.delete(); done_at = -1;
    pulse_start();
    drive_pixels(W*H, 1, 1, 0);
    repeat (4) @(negedge clk);
    chk("rnd_count", obs_q.size(), 49);
    chk("rnd_done_at", done_at, 49);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The block SHALL provide parameter IMG_W, default 16, image width in pixels (even, >=4).
REQ-002 The block SHALL provide parameter IMG_H, default 16, image height in rows (even, >=4).
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 The block SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, frame start request, sampled in IDLE only.
REQ-006 The block SHALL have port pix_vld, input, 1, upstream pixel valid.
REQ-007 The block SHALL have port pix_data, input, 8, raster-order pixel.
REQ-008 The block SHALL have port pix_rdy, output, 1, pixel accept; a transfer occurs when pix_vld && pix_rdy.
REQ-009 The block SHALL have port wgt_ld, input, 1, weight load strobe.
REQ-010 The block SHALL have port wgt_i, input, 72, nine 8-bit 3x3 kernel weights.
REQ-011 The block SHALL have port wgt_o, output, 72, registered weights for the MAC array.
REQ-012 The block SHALL have port win_vld, output, 1, one-cycle window-valid pulse for the MAC vld_i.
REQ-013 The block SHALL have port win_data, output, 128, 4x4 pixel window, row-major; byte 4*i+j = window row i, column j.
REQ-014 The block SHALL have ports win_row and win_col, output, $clog2(IMG_H) and $clog2(IMG_W), top-left output index of the 2x2 output tile (window origin / 2).
REQ-015 The block SHALL have port frame_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN; IDLE->RUN on start; RUN->IDLE on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-017 pix_rdy SHALL be 1 only in RUN; no backpressure from the MAC side.
REQ-018 Column counter SHALL increment per accepted pixel, wrap IMG_W-1->0 and increment row counter; both clear on IDLE->RUN.
REQ-019 Three line buffers (IMG_W bytes each) SHALL hold rows r-3, r-2, r-1; on accepting pixel (r,c) each buffer at column c shifts up by one row and the newest receives pix_data.
REQ-020 On each accept, column {lb0[c], lb1[c], lb2[c], pix_data} SHALL shift into a 4-column window register (oldest column = window column 0).
REQ-021 A window SHALL be emitted when r>=3, r odd, c>=3, c odd (stride 2); win_vld, win_data, win_row=(r-3)/2, win_col=(c-3)/2 are valid the cycle after the accept.
REQ-022 Windows per frame SHALL equal ((IMG_H-2)/2)*((IMG_W-2)/2); 49 for 16x16.
REQ-023 win_data, win_row, win_col SHALL hold their last value when win_vld=0.
REQ-024 frame_done SHALL pulse the cycle after the last pixel accept, coincident with the final win_vld.
REQ-025 wgt_o SHALL load wgt_i on wgt_ld only in IDLE; wgt_ld in RUN is ignored; start and wgt_ld in the same IDLE cycle both take effect.
REQ-026 start during RUN SHALL be ignored; pix_vld during IDLE SHALL not be consumed.
REQ-027 Pixel stalls (pix_vld=0) SHALL freeze counters, buffers and window without emitting.

Reset
REQ-028 Reset SHALL force IDLE, counters 0, pix_rdy 0, win_vld 0, frame_done 0, win_data 0, win_row/win_col 0, wgt_o 0; line buffer contents need not be cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame; no win_vld or frame_done follows release until a new start.

Structure
REQ-030 Shared package conv_pkg SHALL define PIX_W=8, WIN_PIX=16, WIN_W=128, WGT_W=72 and the FSM state enum.
REQ-031 One sub-module conv_line_buf (single-row byte buffer, read-then-write per column) SHALL be instantiated three times.

Verification
REQ-032 16x16 ramp pix=(16r+c)&0xFF, continuous pix_vld -> first win_vld after accept of (3,3): bytes 0,3,4,15 = 0x00,0x03,0x10,0x33; win_row=0, win_col=0.
REQ-033 Same frame -> second window byte0=0x02, win_col=1; total 49 win_vld pulses; last window byte15=0xFF, win_row=6, win_col=6; frame_done coincident with 49th pulse.
REQ-034 Random pix_vld gaps (50%) on the ramp frame -> identical window sequence to REQ-032/033, no extra pulses.
REQ-035 wgt_ld with wgt_i=0x0102..09 in IDLE -> wgt_o updates next cycle; wgt_ld=0xFF.. during RUN -> wgt_o unchanged.
REQ-036 rstn low after 100 accepted pixels -> all outputs 0, IDLE; new start plus full ramp frame -> 49 correct windows.
REQ-037 start pulsed during RUN and pix_vld=1 in IDLE -> no counter restart, pix_rdy=0 in IDLE, no window emitted.
